// File: rtl/cnn_pkg.sv
// Shared types and frame geometry for the CNN frame sequencer.
// Optional lockstep checking in cnn_frame_ctrl is enabled by CNN_FRAME_CTRL_LOCKSTEP_CHK_EN.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam int IMG_W      = 28;
    localparam int K          = 3;
    localparam int NCH        = 4;
    localparam int IMG_SIZE   = IMG_W * IMG_W;
    localparam int OUT_PER_CH = (IMG_W - K + 1) * (IMG_W - K + 1);

endpackage

// File: rtl/cnn_raster_cnt.sv
// Row/column position counter: column wraps at IMG_W-1 and advances the row,
// the row wraps at IMG_W-1 so a finished frame leaves the counter at (0,0).
module cnn_raster_cnt #(
    parameter int IMG_W = 28,
    parameter int CNT_W = 5
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iClr,
    input  logic             iEn,
    output logic [CNT_W-1:0] oRow,
    output logic [CNT_W-1:0] oCol
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(IMG_W - 1);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oRow <= '0;
            oCol <= '0;
        end else if (iClr) begin
            oRow <= '0;
            oCol <= '0;
        end else if (iEn) begin
            if (oCol == LAST) begin
                oCol <= '0;
                oRow <= (oRow == LAST) ? '0 : oRow + 1'b1;
            end else begin
                oCol <= oCol + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_frame_ctrl.sv
// Frame sequencer: streams one IMG_W x IMG_W frame from the pixel buffer into cnn_top,
// counts returned results and reports done or timeout. Macro: CNN_FRAME_CTRL_LOCKSTEP_CHK_EN.
module cnn_frame_ctrl #(
    parameter int WI      = 8,
    parameter int IMG_W   = cnn_pkg::IMG_W,
    parameter int K       = cnn_pkg::K,
    parameter int NCH     = cnn_pkg::NCH,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1024
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr,
    output logic              oRdEn,
    output logic [ADDR_W-1:0] oRdAddr,
    input  logic [WI-1:0]     iRdData,
    input  logic              iStall,
    output logic              oPixelValid,
    output logic [WI-1:0]     oPixelIn,
    input  logic [NCH-1:0]    iConvValid,
    output logic [4:0]        oRow,
    output logic [4:0]        oCol,
    output logic [ADDR_W-1:0] oOutCnt
);

    import cnn_pkg::*;

    localparam int IMG_N  = IMG_W * IMG_W;
    localparam int OUT_N  = (IMG_W - K + 1) * (IMG_W - K + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_N - 1);
    localparam logic [ADDR_W-1:0] OUT_TGT   = ADDR_W'(OUT_N);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [IDLE_W-1:0]   idleCnt;
    logic [ADDR_W-1:0]   cntNext;
    logic                result;
    logic                startGo;
    logic                cntHit;
    logic                timeoutHit;
    logic                lockErr;

    // All channels run in lockstep, so channel 0 stands in for the whole result beat.
    assign result     = iConvValid[0];
    assign startGo    = (state == IDLE || state == ERR) && iStart;
    assign oBusy      = (state == FEED) || (state == DRAIN);
    assign oRdEn      = (state == FEED) && !iStall;
    assign oRdAddr    = oRdEn ? addr : '0;
    assign oPixelIn   = oPixelValid ? iRdData : '0;
    assign cntNext    = (result && oOutCnt != '1) ? oOutCnt + 1'b1 : oOutCnt;
    assign cntHit     = cntNext >= OUT_TGT;
    assign timeoutHit = !result && (idleCnt == IDLE_LAST);

`ifdef CNN_FRAME_CTRL_LOCKSTEP_CHK_EN
    assign lockErr = oBusy && (iConvValid != '0) && (iConvValid != '1);
`else
    logic unusedConvValid;
    assign unusedConvValid = ^iConvValid;
    assign lockErr = 1'b0;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state       <= IDLE;
            addr        <= '0;
            idleCnt     <= '0;
            oOutCnt     <= '0;
            oDone       <= 1'b0;
            oErr        <= 1'b0;
            oPixelValid <= 1'b0;
        end else begin
            oDone       <= 1'b0;
            oPixelValid <= oRdEn;
            case (state)
                IDLE, ERR: begin
                    if (iStart) begin
                        state   <= FEED;
                        addr    <= '0;
                        oOutCnt <= '0;
                        idleCnt <= '0;
                        oErr    <= 1'b0;
                    end
                end
                FEED: begin
                    oOutCnt <= cntNext;
                    idleCnt <= '0;
                    if (lockErr) oErr <= 1'b1;
                    if (!iStall) begin
                        if (addr == ADDR_LAST) state <= DRAIN;
                        else                   addr  <= addr + 1'b1;
                    end
                end
                DRAIN: begin
                    oOutCnt <= cntNext;
                    idleCnt <= result ? '0 : idleCnt + 1'b1;
                    if (lockErr) oErr <= 1'b1;
                    // A full count wins over a timeout landing in the same cycle.
                    if (cntHit) begin
                        oDone <= 1'b1;
                        state <= IDLE;
                    end else if (timeoutHit) begin
                        oErr  <= 1'b1;
                        state <= ERR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cnn_raster_cnt #(
        .IMG_W (IMG_W),
        .CNT_W (5)
    ) uRaster (
        .iClk (iClk),
        .iRst (iRst),
        .iClr (startGo),
        .iEn  (oPixelValid),
        .oRow (oRow),
        .oCol (oCol)
    );

endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Scoreboard bench for cnn_frame_ctrl: expected frame pixels queued at start, popped per valid pixel.
module tb_cnn_frame_ctrl;
    import cnn_pkg::*;

    localparam int WI      = 8;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 1024;
    localparam int MAXC    = 4000;

    typedef struct packed {
        logic [7:0] d;
        logic [4:0] r;
        logic [4:0] c;
    } pix_t;

    logic              iClk = 1'b0;
    logic              iRst = 1'b1;
    logic              iStart = 1'b0;
    logic              iStall = 1'b0;
    logic [NCH-1:0]    iConvValid = '0;
    logic [WI-1:0]     iRdData = '0;
    logic              oBusy, oDone, oErr, oRdEn, oPixelValid;
    logic [ADDR_W-1:0] oRdAddr, oOutCnt;
    logic [WI-1:0]     oPixelIn;
    logic [4:0]        oRow, oCol;

    int errors = 0;
    int checks = 0;

    pix_t sbq[$];
    int   nValid, firstV, lastV, gaps, maxGap, pixErrs, doneCnt, doneCyc, busyFallCyc;
    int   errCyc, lastResCyc, badCyc, cntAtDone, cntAtErr, firstRdAddr, validAtStall;
    int   errAtCyc1, leftOver;
    logic [7:0] stallPix;
    pix_t p29, firstPix, badGot, badExp;
    bit   tmo;

    cnn_frame_ctrl dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iStart      (iStart),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oErr        (oErr),
        .oRdEn       (oRdEn),
        .oRdAddr     (oRdAddr),
        .iRdData     (iRdData),
        .iStall      (iStall),
        .oPixelValid (oPixelValid),
        .oPixelIn    (oPixelIn),
        .iConvValid  (iConvValid),
        .oRow        (oRow),
        .oCol        (oCol),
        .oOutCnt     (oOutCnt)
    );

    always #5 iClk = ~iClk;

    // Synchronous pixel buffer holding addr[7:0] at every address.
    always @(posedge iClk) if (oRdEn) iRdData <= oRdAddr[7:0];

    // Cycle 0 drives iStart; results are returned one per cycle from resStart.
    task automatic run_frame(input int stallAt, input int resStart, input int nRes,
                             input int badIdx, input int restartCyc);
        int   c, post, sent, gapRun;
        bit   seenBusy;
        pix_t e, got;
        nValid = 0; firstV = -1; lastV = -1; gaps = 0; maxGap = 0; pixErrs = 0;
        doneCnt = 0; doneCyc = -1; busyFallCyc = -1; errCyc = -1; lastResCyc = -1;
        badCyc = -1; cntAtDone = -1; cntAtErr = -1; firstRdAddr = -1; validAtStall = -1;
        errAtCyc1 = -1; stallPix = 'x; p29 = 'x; firstPix = 'x; tmo = 0;
        sbq.delete();
        for (int i = 0; i < IMG_SIZE; i++)
            sbq.push_back('{d: 8'(i), r: 5'(i / IMG_W), c: 5'(i % IMG_W)});
        c = 0; post = -1; sent = 0; gapRun = 0; seenBusy = 0;
        while (c < MAXC && !(post >= 0 && c > post + 8)) begin
            @(posedge iClk); #1;
            iStart = (c == 0) || (c == restartCyc);
            iStall = (stallAt >= 0) && (c >= stallAt) && (c < stallAt + 5);
            if (c >= resStart && sent < nRes) begin
                iConvValid = (sent == badIdx) ? 4'b0111 : 4'hF;
                if (sent == badIdx) badCyc = c;
                sent++;
                lastResCyc = c;
            end else begin
                iConvValid = '0;
            end
            @(negedge iClk);
            if (oRdEn && firstRdAddr < 0) firstRdAddr = int'(oRdAddr);
            if (c == 1) errAtCyc1 = int'(oErr);
            if (c == stallAt) begin
                validAtStall = int'(oPixelValid);
                stallPix = oPixelIn;
            end
            if (oPixelValid) begin
                got = '{d: oPixelIn, r: oRow, c: oCol};
                if (firstV < 0) firstV = c;
                lastV = c;
                if (gapRun > 0 && nValid > 0) begin
                    gaps++;
                    if (gapRun > maxGap) maxGap = gapRun;
                end
                gapRun = 0;
                if (nValid == 0) firstPix = got;
                if (nValid == 29) p29 = got;
                if (sbq.size() == 0) begin
                    pixErrs++;
                end else begin
                    e = sbq.pop_front();
                    if (got !== e) begin
                        if (pixErrs == 0) begin badGot = got; badExp = e; end
                        pixErrs++;
                    end
                end
                nValid++;
            end else if (nValid > 0) begin
                gapRun++;
            end
            if (oDone) begin
                doneCnt++;
                doneCyc = c;
                cntAtDone = int'(oOutCnt);
            end
            if (oErr && c >= 1 && errCyc < 0) begin
                errCyc = c;
                cntAtErr = int'(oOutCnt);
            end
            if (oBusy) seenBusy = 1;
            else if (seenBusy && busyFallCyc < 0) begin
                busyFallCyc = c;
                post = c;
            end
            c++;
        end
        tmo = (post < 0);
        leftOver = sbq.size();
        iStart = 0; iStall = 0; iConvValid = '0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge iClk);
        checks++;
        if (|{oBusy, oDone, oErr, oRdEn, oRdAddr, oPixelValid, oPixelIn, oRow, oCol, oOutCnt} !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {oBusy, oDone, oErr, oRdEn, oRdAddr, oPixelValid, oPixelIn, oRow, oCol, oOutCnt});
        end
        iRst = 0;
        repeat (2) @(negedge iClk);
        checks++;
        if ({oBusy, oRdEn, oOutCnt} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b rden=%b cnt=%0d required 0", oBusy, oRdEn, oOutCnt);
        end
    endtask

    task automatic test_stream_done;
        run_frame(-1, 200, OUT_PER_CH, -1, -1);
        checks++; if (tmo !== 0) begin errors++; $display("FAIL stream_timeout: frame never finished"); end
        checks++; if (nValid !== IMG_SIZE) begin errors++; $display("FAIL stream_count: got %0d required %0d", nValid, IMG_SIZE); end
        checks++; if (firstV !== 2) begin errors++; $display("FAIL stream_first_cycle: got %0d required 2", firstV); end
        checks++; if (lastV !== 785) begin errors++; $display("FAIL stream_last_cycle: got %0d required 785", lastV); end
        checks++; if (gaps !== 0) begin errors++; $display("FAIL stream_contiguous: got %0d gaps required 0", gaps); end
        checks++; if (pixErrs !== 0 || leftOver !== 0) begin errors++; $display("FAIL stream_pixels: errs=%0d left=%0d first got %h required %h", pixErrs, leftOver, badGot, badExp); end
        checks++; if (firstPix !== pix_t'({8'h00, 5'd0, 5'd0})) begin errors++; $display("FAIL stream_pix0: got %h required %h", firstPix, pix_t'({8'h00, 5'd0, 5'd0})); end
        checks++; if (p29 !== pix_t'({8'h1D, 5'd1, 5'd1})) begin errors++; $display("FAIL stream_pix29: got %h required %h", p29, pix_t'({8'h1D, 5'd1, 5'd1})); end
        checks++; if (doneCnt !== 1 || doneCyc !== 876) begin errors++; $display("FAIL done_pulse: count=%0d cycle=%0d required 1 at 876", doneCnt, doneCyc); end
        checks++; if (cntAtDone !== OUT_PER_CH) begin errors++; $display("FAIL done_outcnt: got %0d required %0d", cntAtDone, OUT_PER_CH); end
        checks++; if (busyFallCyc !== doneCyc) begin errors++; $display("FAIL done_busy_fall: got %0d required %0d", busyFallCyc, doneCyc); end
        checks++; if (errCyc !== -1) begin errors++; $display("FAIL done_no_err: err at %0d required none", errCyc); end
        repeat (3) begin
            @(posedge iClk); #1; iConvValid = 4'hF;
            @(negedge iClk);
            checks++;
            if (oOutCnt !== ADDR_W'(OUT_PER_CH) || oDone !== 1'b0 || oBusy !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignores_results: cnt=%0d done=%b busy=%b required %0d 0 0", oOutCnt, oDone, oBusy, OUT_PER_CH);
            end
        end
        iConvValid = '0;
    endtask

    task automatic test_stall;
        run_frame(102, 200, OUT_PER_CH, -1, -1);
        checks++; if (validAtStall !== 1 || stallPix !== 8'd100) begin errors++; $display("FAIL stall_inflight: valid=%0d pix=%0d required 1 100", validAtStall, stallPix); end
        checks++; if (gaps !== 1 || maxGap !== 5) begin errors++; $display("FAIL stall_gap: gaps=%0d len=%0d required 1 5", gaps, maxGap); end
        checks++; if (nValid !== IMG_SIZE || pixErrs !== 0 || leftOver !== 0) begin errors++; $display("FAIL stall_pixels: n=%0d errs=%0d left=%0d required %0d 0 0", nValid, pixErrs, leftOver, IMG_SIZE); end
        checks++; if (lastV !== 790) begin errors++; $display("FAIL stall_last_cycle: got %0d required 790", lastV); end
        checks++; if (doneCnt !== 1) begin errors++; $display("FAIL stall_done: got %0d required 1", doneCnt); end
    endtask

    task automatic test_back_to_back;
        // Results finish during FEED and a second iStart arrives while busy.
        run_frame(-1, 50, OUT_PER_CH, -1, 300);
        checks++; if (nValid !== IMG_SIZE || pixErrs !== 0 || leftOver !== 0) begin errors++; $display("FAIL b2b_pixels: n=%0d errs=%0d left=%0d required %0d 0 0", nValid, pixErrs, leftOver, IMG_SIZE); end
        checks++; if (doneCnt !== 1 || doneCyc !== 786) begin errors++; $display("FAIL b2b_done_first_drain: count=%0d cycle=%0d required 1 at 786", doneCnt, doneCyc); end
        checks++; if (cntAtDone !== OUT_PER_CH) begin errors++; $display("FAIL b2b_outcnt: got %0d required %0d", cntAtDone, OUT_PER_CH); end
    endtask

    task automatic test_timeout;
        run_frame(-1, 600, 300, -1, -1);
        checks++; if (lastResCyc !== 899) begin errors++; $display("FAIL tmo_last_result: got %0d required 899", lastResCyc); end
        checks++; if (errCyc !== lastResCyc + TIMEOUT + 1) begin errors++; $display("FAIL tmo_err_cycle: got %0d required %0d", errCyc, lastResCyc + TIMEOUT + 1); end
        checks++; if (doneCnt !== 0) begin errors++; $display("FAIL tmo_no_done: got %0d required 0", doneCnt); end
        checks++; if (cntAtErr !== 300) begin errors++; $display("FAIL tmo_outcnt: got %0d required 300", cntAtErr); end
        checks++; if (busyFallCyc !== errCyc) begin errors++; $display("FAIL tmo_busy_fall: got %0d required %0d", busyFallCyc, errCyc); end
    endtask

    task automatic test_restart_after_err;
        @(negedge iClk);
        checks++; if (oErr !== 1'b1 || oBusy !== 1'b0) begin errors++; $display("FAIL err_state: err=%b busy=%b required 1 0", oErr, oBusy); end
        run_frame(-1, 200, OUT_PER_CH, -1, -1);
        checks++; if (errAtCyc1 !== 0) begin errors++; $display("FAIL restart_err_clear: got %0d required 0", errAtCyc1); end
        checks++; if (firstRdAddr !== 0) begin errors++; $display("FAIL restart_addr: got %0d required 0", firstRdAddr); end
        checks++; if (doneCnt !== 1 || pixErrs !== 0) begin errors++; $display("FAIL restart_frame: done=%0d errs=%0d required 1 0", doneCnt, pixErrs); end
    endtask

    task automatic test_reset_midframe;
        bit found = 0;
        bit sawDone = 0;
        @(posedge iClk); #1 iStart = 1;
        @(posedge iClk); #1 iStart = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge iClk);
            if (oPixelValid && oRow == 5'd14 && oCol == 5'd8) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL midreset_reach_400: pixel 400 not seen"); end
        #2 iRst = 1;
        #1;
        checks++;
        if (|{oBusy, oDone, oErr, oRdEn, oRdAddr, oPixelValid, oPixelIn, oRow, oCol, oOutCnt} !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got %h required 0",
                     {oBusy, oDone, oErr, oRdEn, oRdAddr, oPixelValid, oPixelIn, oRow, oCol, oOutCnt});
        end
        repeat (3) begin @(negedge iClk); if (oDone !== 1'b0) sawDone = 1; end
        checks++; if (sawDone) begin errors++; $display("FAIL midreset_no_done: got done pulse required none"); end
        iRst = 0;
        run_frame(-1, 200, OUT_PER_CH, -1, -1);
        checks++; if (firstRdAddr !== 0) begin errors++; $display("FAIL midreset_addr: got %0d required 0", firstRdAddr); end
        checks++; if (firstPix !== pix_t'({8'h00, 5'd0, 5'd0})) begin errors++; $display("FAIL midreset_pix0: got %h required 0", firstPix); end
        checks++; if (nValid !== IMG_SIZE || pixErrs !== 0 || doneCnt !== 1) begin errors++; $display("FAIL midreset_frame: n=%0d errs=%0d done=%0d required %0d 0 1", nValid, pixErrs, doneCnt, IMG_SIZE); end
    endtask

    task automatic test_lockstep;
        run_frame(-1, 200, OUT_PER_CH, 10, -1);
        checks++; if (badCyc !== 210) begin errors++; $display("FAIL lock_inject: got %0d required 210", badCyc); end
`ifdef CNN_FRAME_CTRL_LOCKSTEP_CHK_EN
        checks++; if (errCyc !== badCyc + 1) begin errors++; $display("FAIL lock_err_cycle: got %0d required %0d", errCyc, badCyc + 1); end
`else
        checks++; if (errCyc !== -1) begin errors++; $display("FAIL lock_err_ignored: got %0d required none", errCyc); end
`endif
        checks++; if (doneCnt !== 1 || cntAtDone !== OUT_PER_CH) begin errors++; $display("FAIL lock_done: done=%0d cnt=%0d required 1 %0d", doneCnt, cntAtDone, OUT_PER_CH); end
    endtask

    initial begin
        test_reset();
        test_stream_done();
        test_stall();
        test_back_to_back();
        test_timeout();
        test_restart_after_err();
        test_reset_midframe();
        test_lockstep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_frame_ctrl.md
Name: cnn_frame_ctrl

Overview:
- Frame sequencer in front of cnn_top.
- On a start command it reads one IMG_W x IMG_W frame from a synchronous pixel buffer and streams it raster-order into the CNN pixel port, honouring a downstream stall.
- Counts the four-channel convolution results returned by the datapath and signals completion, or a timeout error if the pipeline stops producing results.

Parameters:
- WI, 8, pixel width
- IMG_W, 28, frame width and height in pixels
- K, 3, convolution kernel size; expected outputs per channel = (IMG_W-K+1)^2 = 676
- NCH, 4, number of conv channels
- ADDR_W, 10, buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_W
- TIMEOUT, 1024, maximum cycles with no result while in DRAIN

Ports:
- iClk  in  1  clock, rising edge
- iRst  in  1  reset, asynchronous, active-high
- iStart  in  1  start-frame request; level sampled
- oBusy  out  1  high in FEED and DRAIN
- oDone  out  1  one-cycle pulse: frame complete
- oErr  out  1  sticky timeout/lockstep error
- oRdEn  out  1  buffer read enable
- oRdAddr  out  ADDR_W  buffer read address
- iRdData  in  WI  buffer data, valid 1 cycle after oRdEn
- iStall  in  1  downstream requests pause in pixel issue
- oPixelValid  out  1  to cnn_top iPixelValid
- oPixelIn  out  WI  to cnn_top iPixelIn
- iConvValid  in  NCH  cnn_top oValid
- oRow  out  5  row of the pixel on oPixelIn
- oCol  out  5  column of the pixel on oPixelIn
- oOutCnt  out  ADDR_W  results counted this frame

Behaviour:
- Reset, asynchronous on iRst high:
  - State IDLE.
  - All outputs 0; address, row/col and result counters 0.
- States IDLE, FEED, DRAIN, ERR.
- IDLE:
  - iStart=1 -> FEED next cycle.
  - Clears oErr, oOutCnt and the address counter on that transition.
  - iConvValid is ignored.
- FEED:
  - Each cycle with iStall=0: oRdEn=1 with oRdAddr=addr, then addr++.
  - iStall=1: oRdEn=0 and addr holds.
  - After issuing addr = IMG_W*IMG_W-1, go to DRAIN.
- Pixel path:
  - oPixelValid is oRdEn delayed 1 cycle; oPixelIn = iRdData in the same cycle.
  - oRow/oCol are registered alongside and advance col 0..IMG_W-1, wrapping to 0 with row++.
  - A read issued the cycle before iStall rises still emits its pixel (1-cycle slack). cnn_top must accept it.
- Latency:
  - With no stall, first oPixelValid is 1 cycle after entering FEED.
  - Exactly 784 contiguous valid pixels are produced.
  - The last pixel appears 784 cycles after FEED entry.
- Result counting, FEED and DRAIN:
  - Each cycle with iConvValid[0]=1 increments oOutCnt.
  - The channels are required to be in lockstep.
- DRAIN:
  - When oOutCnt reaches 676 (including the increment this cycle): oDone=1 for one cycle, then IDLE.
  - If the count reaches 676 during FEED, feeding completes first; oDone fires on the first DRAIN cycle.
  - An idle counter resets on every iConvValid[0]. At TIMEOUT cycles without a result: go to ERR with oErr=1.
- ERR:
  - oBusy=0, oErr held.
  - iStart -> FEED, clearing oErr as from IDLE.
- iStart while oBusy=1 is ignored.
- iConvValid after oDone, while IDLE, is ignored.
- Reset mid-frame aborts immediately: no oDone, outputs 0.
- Width rules:
  - oOutCnt saturates at 2^ADDR_W-1.
  - The address counter never exceeds IMG_W*IMG_W-1.

Optional Feature:
- CNN_FRAME_CTRL_LOCKSTEP_CHK_EN defined:
  - Any cycle in FEED/DRAIN where iConvValid is neither all-0 nor all-1 sets oErr immediately.
  - oErr stays sticky; the frame still runs to DONE/timeout.
- Undefined: only iConvValid[0] is observed, and oErr is set by timeout alone.

Decomposition:
- Shared package cnn_pkg holds:
  - the state encoding typedef (IDLE/FEED/DRAIN/ERR)
  - IMG_W, K, NCH
  - derived constants IMG_SIZE = IMG_W*IMG_W and OUT_PER_CH = (IMG_W-K+1)^2
- One natural sub-module, cnn_raster_cnt: row/column counter with wrap and enable, reused for oRow/oCol.
- The FSM, address counter, result counter and timeout counter stay in cnn_frame_ctrl.

Test Plan:
- Reset, then iStart pulse with no stall, buffer filled with addr[7:0] -> 784 contiguous oPixelValid cycles, first pixel 0x00 at row 0 col 0. Pixel 29 = 0x1D at row 1 col 1.
- Model returning 676 iConvValid=4'hF pulses -> oOutCnt=676, a single oDone pulse, oBusy falls the same cycle, state returns to IDLE.
- iStall high for 5 cycles at pixel 100 -> exactly one in-flight pixel emitted after the stall rises, then a 5-cycle gap. No pixel lost or duplicated; total still 784.
- Model stops after 300 results -> oErr=1 exactly TIMEOUT cycles after the last result, with no oDone. A later iStart clears oErr and restarts at address 0.
- iRst asserted mid-FEED at pixel 400 -> all outputs 0 asynchronously. iStart after release restarts at address 0, row/col 0.
- With CNN_FRAME_CTRL_LOCKSTEP_CHK_EN, inject iConvValid=4'b0111 once -> oErr=1 the next cycle. The frame still reaches oDone after 676 counted results. Without the macro, oErr stays 0.
